// File: rtl/grf_write_scoreboard.sv
// Per-register pending-write scoreboard for the GRF: counts issued writes per
// destination, retires them from WB, and stalls ID readers on unretired producers.

module grf_pend_cnt #(
  parameter int W = 2
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_flush,
  input  logic         i_inc,
  input  logic         i_dec,
  output logic [W-1:0] o_cnt,
  output logic         o_uf
);
  logic [W-1:0] r_cnt;

  // Issue and retire to the same register in one cycle cancel out.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)                                r_cnt <= '0;
    else if (i_flush)                           r_cnt <= '0;
    else if (i_inc && !i_dec)                   r_cnt <= r_cnt + W'(1);
    else if (i_dec && !i_inc && r_cnt != '0)    r_cnt <= r_cnt - W'(1);
  end

  assign o_cnt = r_cnt;
  assign o_uf  = i_dec & ~i_inc & (r_cnt == '0);
endmodule

module grf_write_scoreboard #(
  parameter int PENDING_WIDTH = 2
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_issue_valid,
  input  logic        i_issue_write_enable,
  input  logic [4:0]  i_issue_addr,
  output logic        o_issue_ready,
  input  logic        i_retire_valid,
  input  logic        i_retire_write_enable,
  input  logic [4:0]  i_retire_addr,
  input  logic        i_flush,
  input  logic [4:0]  i_rs_addr,
  input  logic [4:0]  i_rt_addr,
  output logic        o_rs_pending,
  output logic        o_rt_pending,
  output logic        o_stall,
  output logic [31:0] o_busy_mask,
  output logic        o_underflow_err
);
  localparam logic [PENDING_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [PENDING_WIDTH-1:0] CNT_ONE = PENDING_WIDTH'(1);

  logic [31:0][PENDING_WIDTH-1:0] w_cnt;
  logic [31:0]                    w_iss_oh, w_ret_oh, w_uf;
  logic [PENDING_WIDTH-1:0]       w_rs_cnt, w_rt_cnt, w_iss_cnt;
  logic                           w_iss, w_ret, w_iss_wr;
  logic                           r_underflow;

  assign w_cnt[0] = '0;
  assign w_uf[0]  = 1'b0;

  genvar g;
  generate
    for (g = 1; g < 32; g++) begin : g_reg
      grf_pend_cnt #(.W(PENDING_WIDTH)) u_cnt (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_flush (i_flush),
        .i_inc   (w_iss_oh[g]),
        .i_dec   (w_ret_oh[g]),
        .o_cnt   (w_cnt[g]),
        .o_uf    (w_uf[g])
      );
    end
  endgenerate

  assign w_rs_cnt  = w_cnt[i_rs_addr];
  assign w_rt_cnt  = w_cnt[i_rt_addr];
  assign w_iss_cnt = w_cnt[i_issue_addr];

  assign w_ret = i_retire_valid & i_retire_write_enable & (i_retire_addr != 5'd0);

  // A last outstanding write retiring this cycle is covered by GRF write-through.
  assign o_rs_pending = (i_rs_addr != 5'd0) &
                        ((w_rs_cnt > CNT_ONE) |
                         ((w_rs_cnt == CNT_ONE) & ~(w_ret & (i_retire_addr == i_rs_addr))));
  assign o_rt_pending = (i_rt_addr != 5'd0) &
                        ((w_rt_cnt > CNT_ONE) |
                         ((w_rt_cnt == CNT_ONE) & ~(w_ret & (i_retire_addr == i_rt_addr))));
  assign o_stall      = o_rs_pending | o_rt_pending;

  assign w_iss_wr      = i_issue_write_enable & (i_issue_addr != 5'd0);
  assign o_issue_ready = ~o_stall & ~(w_iss_wr & (w_iss_cnt == CNT_MAX));
  assign w_iss         = i_issue_valid & o_issue_ready & w_iss_wr;

  assign w_iss_oh = w_iss ? (32'd1 << i_issue_addr)  : 32'd0;
  assign w_ret_oh = w_ret ? (32'd1 << i_retire_addr) : 32'd0;

  always_comb begin
    o_busy_mask = '0;
    for (int i = 1; i < 32; i++) o_busy_mask[i] = |w_cnt[i];
  end

  // Sticky until reset; a flush cycle still records an underflow.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_underflow <= 1'b0;
    else         r_underflow <= r_underflow | (|w_uf);
  end

  assign o_underflow_err = r_underflow;
endmodule

// File: tb/tb_grf_write_scoreboard.sv
// Self-checking bench for grf_write_scoreboard: directed vector table, a
// mid-cycle reset sequence, and random traffic against a per-register count model.

module tb_grf_write_scoreboard;
  localparam int PW   = 2;
  localparam int MAXC = (1 << PW) - 1;

  logic        clk = 1'b0, rst = 1'b1;
  logic        iv, iwe, rv, rwe, fl;
  logic [4:0]  ia, ra, rs, rt;
  logic        rdy, rsp, rtp, stl, uf;
  logic [31:0] busy;

  always #5 clk = ~clk;

  grf_write_scoreboard #(.PENDING_WIDTH(PW)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_issue_valid(iv), .i_issue_write_enable(iwe), .i_issue_addr(ia),
    .o_issue_ready(rdy),
    .i_retire_valid(rv), .i_retire_write_enable(rwe), .i_retire_addr(ra),
    .i_flush(fl), .i_rs_addr(rs), .i_rt_addr(rt),
    .o_rs_pending(rsp), .o_rt_pending(rtp), .o_stall(stl),
    .o_busy_mask(busy), .o_underflow_err(uf)
  );

  typedef struct {
    logic iv, iwe; logic [4:0] ia;
    logic rv, rwe; logic [4:0] ra;
    logic fl; logic [4:0] rs, rt;
    logic e_rdy, e_rsp, e_rtp, e_stl; logic [31:0] e_busy; logic e_uf;
  } vec_t;

  int n_cmp = 0, n_err = 0;
  int mcnt [32];
  bit muf;

  function automatic vec_t mk(input logic v, we, input int a, input logic r, rw, input int b,
                              input logic f, input int s, t,
                              input logic erdy, ersp, ertp, estl, input logic [31:0] ebusy,
                              input logic euf);
    vec_t x;
    x.iv = v; x.iwe = we; x.ia = 5'(a); x.rv = r; x.rwe = rw; x.ra = 5'(b);
    x.fl = f; x.rs = 5'(s); x.rt = 5'(t);
    x.e_rdy = erdy; x.e_rsp = ersp; x.e_rtp = ertp; x.e_stl = estl;
    x.e_busy = ebusy; x.e_uf = euf;
    return x;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h, want %h", nm, $time, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    iv = v.iv; iwe = v.iwe; ia = v.ia; rv = v.rv; rwe = v.rwe; ra = v.ra;
    fl = v.fl; rs = v.rs; rt = v.rt;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mcnt[i] = 0;
    muf = 0;
  endtask

  // Expected combinational outputs from the model counts and the current inputs.
  task automatic model_eval(output bit erdy, ersp, ertp, estl, output logic [31:0] ebusy);
    bit ret;
    ret  = rv && rwe && ra != 0;
    ersp = rs != 0 && (mcnt[rs] > 1 || (mcnt[rs] == 1 && !(ret && ra == rs)));
    ertp = rt != 0 && (mcnt[rt] > 1 || (mcnt[rt] == 1 && !(ret && ra == rt)));
    estl = ersp || ertp;
    erdy = !estl && !(iwe && ia != 0 && mcnt[ia] == MAXC);
    ebusy = '0;
    for (int i = 1; i < 32; i++) ebusy[i] = mcnt[i] > 0;
  endtask

  task automatic model_step();
    bit erdy, ersp, ertp, estl, iss, ret;
    logic [31:0] ebusy;
    model_eval(erdy, ersp, ertp, estl, ebusy);
    iss = iv && erdy && iwe && ia != 0;
    ret = rv && rwe && ra != 0;
    if (ret && mcnt[ra] == 0 && !(iss && ia == ra)) muf = 1;
    if (fl) begin
      for (int i = 0; i < 32; i++) mcnt[i] = 0;
    end else begin
      if (iss && !(ret && ra == ia)) mcnt[ia] = mcnt[ia] + 1;
      if (ret && !(iss && ia == ra) && mcnt[ra] > 0) mcnt[ra] = mcnt[ra] - 1;
    end
  endtask

  task automatic check_model(input string tag);
    bit erdy, ersp, ertp, estl;
    logic [31:0] ebusy;
    model_eval(erdy, ersp, ertp, estl, ebusy);
    chk({tag, ".issue_ready"}, 32'(rdy), 32'(erdy));
    chk({tag, ".rs_pending"},  32'(rsp), 32'(ersp));
    chk({tag, ".rt_pending"},  32'(rtp), 32'(ertp));
    chk({tag, ".stall"},       32'(stl), 32'(estl));
    chk({tag, ".busy_mask"},   busy,     ebusy);
    chk({tag, ".underflow"},   32'(uf),  32'(muf));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  vec_t tbl [21];
  vec_t idle;

  initial begin
    idle = mk(0,0,0, 0,0,0, 0,0,0, 1,0,0,0, 32'h0, 0);
    drive(idle);
    model_reset();

    //           iv we ia  rv rwe ra fl rs rt  rdy rsp rtp stl busy          uf
    tbl[0]  = mk(0, 0, 0,  0, 0,  0, 0, 0, 0,  1,  0,  0,  0,  32'h0,        0);
    tbl[1]  = mk(1, 1, 8,  0, 0,  0, 0, 0, 0,  1,  0,  0,  0,  32'h0,        0);
    tbl[2]  = mk(0, 0, 0,  0, 0,  0, 0, 8, 0,  0,  1,  0,  1,  32'h100,      0);
    tbl[3]  = mk(0, 0, 0,  1, 1,  8, 0, 0, 8,  1,  0,  0,  0,  32'h100,      0);
    tbl[4]  = mk(0, 0, 0,  0, 0,  0, 0, 8, 8,  1,  0,  0,  0,  32'h0,        0);
    tbl[5]  = mk(1, 1, 9,  0, 0,  0, 0, 0, 0,  1,  0,  0,  0,  32'h0,        0);
    tbl[6]  = mk(1, 1, 9,  0, 0,  0, 0, 0, 0,  1,  0,  0,  0,  32'h200,      0);
    tbl[7]  = mk(1, 1, 9,  0, 0,  0, 0, 0, 0,  1,  0,  0,  0,  32'h200,      0);
    tbl[8]  = mk(1, 1, 9,  0, 0,  0, 0, 0, 0,  0,  0,  0,  0,  32'h200,      0);
    tbl[9]  = mk(1, 1, 9,  1, 1,  9, 0, 0, 0,  0,  0,  0,  0,  32'h200,      0);
    tbl[10] = mk(0, 1, 9,  0, 0,  0, 0, 0, 0,  1,  0,  0,  0,  32'h200,      0);
    tbl[11] = mk(1, 1, 5,  0, 0,  0, 0, 0, 0,  1,  0,  0,  0,  32'h200,      0);
    tbl[12] = mk(1, 1, 5,  1, 1,  5, 0, 0, 0,  1,  0,  0,  0,  32'h220,      0);
    tbl[13] = mk(0, 0, 0,  0, 0,  0, 0, 5, 0,  0,  1,  0,  1,  32'h220,      0);
    tbl[14] = mk(1, 1, 0,  1, 1,  0, 0, 0, 0,  1,  0,  0,  0,  32'h220,      0);
    tbl[15] = mk(0, 0, 0,  1, 1, 12, 0, 0, 0,  1,  0,  0,  0,  32'h220,      0);
    tbl[16] = mk(1, 1, 3,  0, 0,  0, 0, 0, 0,  1,  0,  0,  0,  32'h220,      1);
    tbl[17] = mk(1, 1, 3,  0, 0,  0, 0, 0, 0,  1,  0,  0,  0,  32'h228,      1);
    tbl[18] = mk(1, 1, 4,  0, 0,  0, 0, 0, 0,  1,  0,  0,  0,  32'h228,      1);
    tbl[19] = mk(1, 1, 7,  0, 0,  0, 1, 0, 0,  1,  0,  0,  0,  32'h238,      1);
    tbl[20] = mk(0, 0, 0,  0, 0,  0, 0, 7, 3,  1,  0,  0,  0,  32'h0,        1);

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 21; i++) begin
      drive(tbl[i]);
      #3;
      chk($sformatf("vec%0d.issue_ready", i), 32'(rdy), 32'(tbl[i].e_rdy));
      chk($sformatf("vec%0d.rs_pending", i),  32'(rsp), 32'(tbl[i].e_rsp));
      chk($sformatf("vec%0d.rt_pending", i),  32'(rtp), 32'(tbl[i].e_rtp));
      chk($sformatf("vec%0d.stall", i),       32'(stl), 32'(tbl[i].e_stl));
      chk($sformatf("vec%0d.busy_mask", i),   busy,     tbl[i].e_busy);
      chk($sformatf("vec%0d.underflow", i),   32'(uf),  32'(tbl[i].e_uf));
      tick();
    end

    // Mid-cycle asynchronous reset with pending writes and a set underflow flag.
    drive(mk(1,1,3, 0,0,0, 0,0,0, 1,0,0,0, 32'h0, 0)); tick();
    drive(mk(1,1,6, 0,0,0, 0,0,0, 1,0,0,0, 32'h0, 0)); tick();
    drive(mk(0,0,0, 0,0,0, 0,3,6, 1,0,0,0, 32'h0, 0));
    #1;
    check_model("pre_reset");
    rst = 1'b1;
    #1;
    chk("async_reset.busy_mask",  busy,     32'h0);
    chk("async_reset.underflow",  32'(uf),  32'h0);
    chk("async_reset.stall",      32'(stl), 32'h0);
    chk("async_reset.issue_ready",32'(rdy), 32'h1);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;

    // Random traffic on a small register window to force collisions and saturation.
    for (int c = 0; c < 600; c++) begin
      if (c % 120 == 119) begin
        rst = 1'b1;
        #1;
        chk("rand_reset.busy_mask", busy, 32'h0);
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
      end
      iv  = ($urandom % 4) != 0;
      iwe = ($urandom % 5) != 0;
      ia  = 5'($urandom_range(0, 6));
      rv  = ($urandom % 2) != 0;
      rwe = ($urandom % 5) != 0;
      ra  = 5'($urandom_range(0, 6));
      fl  = ($urandom % 30) == 0;
      rs  = ($urandom % 3 == 0) ? 5'($urandom_range(0, 6)) : 5'd0;
      rt  = ($urandom % 3 == 0) ? 5'($urandom_range(0, 6)) : 5'd0;
      #3;
      check_model($sformatf("rand%0d", c));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/grf_write_scoreboard.md
# grf_write_scoreboard

Per-register pending-write tracker for the pipelined MIPS core, the consumer end of the GRF write-enable/write-address decode. On the issue side it accepts each instruction's decoded GRF write enable and destination, and counts it as in flight. On the write-back side it retires the matching write. Readers in ID query whether `rs`/`rt` still have an unretired producer, and the block raises `stall` until the value is architecturally available; the GRF internal write-through covers the retire cycle.

## Interface
- `PENDING_WIDTH`, default 2: width of each per-register in-flight counter. Maximum outstanding writes per register is 2^PENDING_WIDTH − 1.
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `issue_valid`  in  1  ID presents an instruction this cycle.
- `issue_write_enable`  in  1  decoded GRF write enable of the issuing instruction.
- `issue_addr`  in  5  decoded GRF write address of the issuing instruction.
- `issue_ready`  out  1  issue is accepted this cycle when `issue_valid & issue_ready`.
- `retire_valid`  in  1  WB stage holds a valid instruction.
- `retire_write_enable`  in  1  decoded GRF write enable in WB.
- `retire_addr`  in  5  decoded GRF write address in WB.
- `flush`  in  1  pipeline flush (exception/eret); discards all in-flight writes.
- `rs_addr`, `rt_addr`  in  5 each  ID read addresses.
- `rs_pending`, `rt_pending`  out  1 each  register has an unretired producer.
- `stall`  out  1  `rs_pending | rt_pending`.
- `busy_mask`  out  32  bit i = register i has count > 0 (bit 0 always 0).
- `underflow_err`  out  1  sticky; a retire hit a zero counter.

## Operation
- State: 31 counters `cnt[1..31]` of PENDING_WIDTH bits, plus `underflow_err`. `cnt[0]` is a hard zero.
- Effective issue: `iss = issue_valid & issue_ready & issue_write_enable & (issue_addr != 0)`.
- Effective retire: `ret = retire_valid & retire_write_enable & (retire_addr != 0)`.
- `issue_ready = ~stall & ~(issue_write_enable & issue_addr != 0 & cnt[issue_addr] == max)`.
- Counter update, per register r:
  - `iss` to r only: +1.
  - `ret` to r only: −1.
  - Both to r: unchanged.
  - Neither: unchanged.
- Retire to a zero counter, not offset by an issue to the same register: the counter stays 0 and `underflow_err` is set. It stays set until reset; flush does not clear it.
- `flush`: next state of every counter is 0, and this overrides issue and retire in the same cycle. `underflow_err` is still evaluated on the flush cycle.
- Retire bypass: `rs_pending = (rs_addr != 0) & (cnt[rs_addr] > 1 | (cnt[rs_addr] == 1 & ~(ret & retire_addr == rs_addr)))`. `rt_pending` is formed the same way from `rt_addr`.
- `busy_mask` reflects registered counters only; it has no bypass.
- No FSM beyond the counters. `issue_ready`, `*_pending`, `stall` and `busy_mask` are combinational from state plus current inputs.

## Timing
- Reset values:
  - All counters 0.
  - `busy_mask` 0 and `underflow_err` 0.
  - `rs_pending`, `rt_pending`, `stall` 0, since counters are 0.
  - `issue_ready` 1.
- Issue accepted in cycle N: the register reads pending from cycle N+1. An instruction never stalls on its own destination.
- Retire in cycle N of the last outstanding write: the reader is not pending in cycle N (bypass), and the counter is 0 at N+1.
- Flush in cycle N: all pending and `stall` deassert from N+1.
- Reset asserted mid-operation clears state within the same cycle, independent of `clk`.
- Saturation at max: issue is held off (`issue_ready` = 0) and the counter never wraps.
- Writes to register 0 are ignored on both ports, and register 0 is never pending.

## Test plan
- Reset, then issue `$8` (we=1) in cycle 1. In cycle 2, `rs_addr`=8 → `rs_pending`=1, `stall`=1, `issue_ready`=0, `busy_mask`=0x00000100.
- Retire `$8` in cycle 3 with `rt_addr`=8 → `rt_pending`=0 that cycle (bypass); `busy_mask`=0 in cycle 4.
- Issue `$9` three times with no readers (PENDING_WIDTH=2), then present a 4th `$9` issue → `issue_ready`=0 and counter stays 3. Retire one → `issue_ready`=1 next cycle.
- Issue `$5` and retire `$5` in the same cycle with count 1 → count stays 1. `$0` issue/retire → no effect and `underflow_err`=0.
- Retire `$12` with count 0 → `underflow_err`=1, which persists through a later flush. Only `reset` clears it.
- With `$3`=2 and `$4`=1 pending, assert flush together with an issue to `$7` → all counters 0 next cycle and `$7` not pending. Asserting `reset` mid-cycle drops `busy_mask` to 0 before the next edge.
